seg7_scanner: RTL and testbench
===============================

# seg7_scanner

Multiplexed four-digit seven-segment driver downstream of the CPU core. Captures the 16-bit value the core publishes, holds it tear-free until a frame boundary, and time-multiplexes the four hex digits onto the shared `SEG`/`SEG_SEL` board pins. Also shows the core's halt status on a decimal point.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles per digit slot; legal range 2..2^20.
- `BLANK_LZ`, default 1: when 1, leading-zero digits are blanked.
- `clk`  in  1  system clock, the same clock the core runs on.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `in_valid`  in  1  one-cycle strobe; `in_value` is sampled on this cycle.
- `in_value`  in  16  value to display; nibble 0 (bits 3:0) maps to the rightmost digit.
- `in_halt`  in  1  level; core halted.
- `SEG`  out  8  active-low segments; bit 7 = dp, bits 6:0 = g,f,e,d,c,b,a.
- `SEG_SEL`  out  4  active-low one-hot digit enable; bit 0 = rightmost digit.

## Operation
- Registers:
  - prescaler `div_cnt`, 20 bits.
  - digit index `dig`, 2 bits.
  - `pend_val` and `pend_flag`.
  - `disp_val`, 16 bits.
  - `halt_q`.
- `tick` is asserted when `div_cnt == REFRESH_DIV-1`. On `tick`, `div_cnt` goes to 0; otherwise it increments.
- On `tick`, `dig` advances 0→1→2→3→0. The step 3→0 is the frame boundary.
- Capture:
  - `in_valid` loads `pend_val` and sets `pend_flag`.
  - Several strobes within one frame: the last one wins.
- Commit:
  - At the frame boundary with `pend_flag` set, `disp_val` ← `pend_val` and `pend_flag` is cleared.
  - If `in_valid` coincides with the boundary tick, `in_value` goes straight to `disp_val` and `pend_flag` ends cleared.
- `halt_q` samples `in_halt` every cycle. It is not frame-synchronised.
- Digit output, registered on `tick` using the new `dig`:
  - Nibble = `disp_val[4*dig +: 4]`, passed through the hex font.
  - `SEG_SEL` = ~(1 << dig).
  - dp is lit only when `dig == 0` and `halt_q == 1`.
- Leading-zero blanking, `BLANK_LZ=1`:
  - Digit k is blanked (segments 7'h7F) when k > 0 and all nibbles at index ≥ k are zero.
  - Digit 0 is never blanked, so value 0 shows "0".
  - Blanking never suppresses the dp.
- Font, g..a active-low:
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78
  - 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E
- Reset, asynchronous, at any time:
  - `SEG`=8'hFF, `SEG_SEL`=4'hF.
  - `div_cnt`=0, `dig`=3, `disp_val`=0, `pend_flag`=0, `halt_q`=0.
  - Starting with `dig`=3 makes the first tick select digit 0.

## Timing
- After reset release, outputs stay blank (8'hFF/4'hF) for `REFRESH_DIV` cycles.
- The first `tick` drives digit 0 from the next edge onward.
- Each digit is held exactly `REFRESH_DIV` cycles. A full frame is 4·`REFRESH_DIV` cycles.
- Latency from `in_valid` to visibility: the value appears at the next frame boundary that is not earlier than the strobe cycle. Worst case is 4·`REFRESH_DIV` cycles.
- No digit ever shows a mix of old and new `disp_val`.
- `halt_q` reaches dp one cycle after `in_halt`, at the next digit-0 slot.
- Outputs change only on `tick` edges and on reset. They are glitch-free registered outputs.

## Structure
- Package `seg7_pkg` holds:
  - `localparam int DIGITS = 4`.
  - The 16-entry font constant array.
  - `typedef logic [3:0] nibble_t`.
  - `typedef logic [7:0] seg_t`.
- Sub-module `seg7_decode` is the combinational nibble + blank + dp → `seg_t` lookup.
- The top level holds the prescaler, the scan counter, the pending/commit logic and the output registers.

## Test plan
All scenarios use `REFRESH_DIV=4`.
- Reset, then idle for 4 cycles → `SEG`=FF and `SEG_SEL`=F. On cycle 5, `SEG_SEL`=E and `SEG`=C0 ("0").
- `in_valid` with 16'h12AF mid-frame:
  - The current frame still shows 0.
  - After the boundary the digits are 0: `SEG`=8E (F) with `SEG_SEL`=E; 1: 88 (A) with D; 2: A4 (2) with B; 3: F9 (1) with 7.
- `in_valid` 16'h0005 then 16'h0030 in the same frame → only 0030 appears. Digit 3 is blank (FF), digit 2 is blank (FF), digit 1 is B0, digit 0 is C0.
- `in_valid` exactly on the boundary tick with 16'hBEEF → committed in that same tick. Digit 0 shows 8E in the following slot.
- `in_halt`=1 with value 0 → digit-0 slot shows `SEG`=40 (dp lit). Other slots show FF.
- Assert `rst` mid-slot with `disp_val`=FFFF → outputs go to FF/F immediately (asynchronously). After release, blank for 4 cycles, then "0".

Source files
------------

// File: rtl/seg7_scanner_pkg.sv
// rtl/seg7_scanner_pkg.sv - shared types, hex font and segment encoder for the seven-segment scanner
package seg7_pkg;

  localparam int DIGITS = 4;
  localparam int VAL_W  = 4 * DIGITS;

  typedef logic [3:0] nibble_t;
  typedef logic [7:0] seg_t;

  // g..a, active-low, indexed by nibble value
  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0]        SEG_BLANK = 7'h7F;
  localparam seg_t              SEG_OFF   = 8'hFF;
  localparam logic [DIGITS-1:0] SEL_OFF   = '1;

  // dp is kept independent of blanking so a halted core is always visible
  function automatic seg_t seg_encode(input nibble_t nib, input logic blank, input logic dp);
    logic [6:0] w_glyph;
    w_glyph = blank ? SEG_BLANK : FONT[nib];
    return {~dp, w_glyph};
  endfunction

endpackage

// File: rtl/seg7_scanner_if.sv
// rtl/seg7_scanner_if.sv - core-side value/halt inputs and board-side segment pins
interface seg7_scanner_if;
  import seg7_pkg::*;

  logic                in_valid;
  logic [VAL_W-1:0]    in_value;
  logic                in_halt;
  seg_t                SEG;
  logic [DIGITS-1:0]   SEG_SEL;

  modport master (
    output in_valid,
    output in_value,
    output in_halt,
    input  SEG,
    input  SEG_SEL
  );

  modport slave (
    input  in_valid,
    input  in_value,
    input  in_halt,
    output SEG,
    output SEG_SEL
  );

endinterface

// File: rtl/seg7_scanner_decode.sv
// rtl/seg7_scanner_decode.sv - combinational nibble/blank/dp to active-low segment lookup
module seg7_decode
  import seg7_pkg::*;
(
  input  nibble_t i_nibble,
  input  logic    i_blank,
  input  logic    i_dp,
  output seg_t    o_seg
);

  assign o_seg = seg_encode(i_nibble, i_blank, i_dp);

endmodule

// File: rtl/seg7_scanner.sv
// rtl/seg7_scanner.sv - four-digit multiplexed hex display with frame-synchronous value commit
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1
) (
  input  logic            clk,
  input  logic            rst,
  seg7_scanner_if.slave   bus
);

  localparam int DIG_W = $clog2(DIGITS);

  logic [19:0]        r_div_cnt;
  logic [DIG_W-1:0]   r_dig;
  logic [VAL_W-1:0]   r_pend_val;
  logic               r_pend_flag;
  logic [VAL_W-1:0]   r_disp_val;
  logic               r_halt_q;
  seg_t               r_seg;
  logic [DIGITS-1:0]  r_sel;

  logic               w_tick;
  logic               w_frame;
  logic [DIG_W-1:0]   w_dig_nxt;
  logic [VAL_W-1:0]   w_disp_nxt;
  logic [VAL_W-1:0]   w_upper;
  logic               w_blank;
  logic               w_dp;
  seg_t               w_seg;
  logic [DIGITS-1:0]  w_sel;

  assign w_tick    = (r_div_cnt == 20'(REFRESH_DIV - 1));
  assign w_dig_nxt = r_dig + DIG_W'(1);
  assign w_frame   = w_tick && (r_dig == DIG_W'(DIGITS - 1));

  // A strobe landing on the boundary bypasses the pending register
  always_comb begin
    w_disp_nxt = r_disp_val;
    if (w_frame) begin
      if (bus.in_valid) begin
        w_disp_nxt = bus.in_value;
      end else if (r_pend_flag) begin
        w_disp_nxt = r_pend_val;
      end
    end
  end

  // Digit k sees nibbles k and above in w_upper; all-zero means it is a leading zero
  assign w_upper = w_disp_nxt >> {w_dig_nxt, 2'b00};
  assign w_blank = (BLANK_LZ != 0) && (w_dig_nxt != '0) && (w_upper == '0);
  assign w_dp    = (w_dig_nxt == '0) && r_halt_q;
  assign w_sel   = ~(DIGITS'(1) << w_dig_nxt);

  seg7_decode u_decode (
    .i_nibble (w_upper[3:0]),
    .i_blank  (w_blank),
    .i_dp     (w_dp),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt   <= '0;
      r_dig       <= '1;
      r_pend_val  <= '0;
      r_pend_flag <= 1'b0;
      r_disp_val  <= '0;
      r_halt_q    <= 1'b0;
      r_seg       <= SEG_OFF;
      r_sel       <= SEL_OFF;
    end else begin
      r_halt_q   <= bus.in_halt;
      r_disp_val <= w_disp_nxt;

      if (w_tick) begin
        r_div_cnt <= '0;
        r_dig     <= w_dig_nxt;
        r_seg     <= w_seg;
        r_sel     <= w_sel;
      end else begin
        r_div_cnt <= r_div_cnt + 20'd1;
      end

      if (bus.in_valid && !w_frame) begin
        r_pend_val  <= bus.in_value;
        r_pend_flag <= 1'b1;
      end else if (w_frame) begin
        r_pend_flag <= 1'b0;
      end
    end
  end

  assign bus.SEG     = r_seg;
  assign bus.SEG_SEL = r_sel;

endmodule

// File: tb/tb_seg7_scanner.sv
// tb/tb_seg7_scanner.sv - directed self-checking bench for seg7_scanner with REFRESH_DIV=4
module tb_seg7_scanner;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  seg7_scanner_if bus ();

  seg7_scanner #(
    .REFRESH_DIV (4),
    .BLANK_LZ    (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic slot(input string tag, input logic [7:0] seg, input logic [3:0] sel);
    chk({tag, "_seg"}, {8'h00, bus.SEG}, {8'h00, seg});
    chk({tag, "_sel"}, {12'h000, bus.SEG_SEL}, {12'h000, sel});
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] v);
    bus.in_valid = 1'b1;
    bus.in_value = v;
    adv(1);
    bus.in_valid = 1'b0;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_value = 16'h0000;
    bus.in_halt  = 1'b0;
    repeat (2) @(posedge clk);
    release_rst();

    // ticks fall on posedges 4,8,12,...; edge 4+16m is a frame boundary
    slot("rst", 8'hFF, 4'hF);
    adv(3);
    slot("pre_tick", 8'hFF, 4'hF);
    adv(1);                                   // e4
    slot("zero_d0", 8'hC0, 4'hE);
    adv(4);                                   // e8
    slot("zero_d1", 8'hFF, 4'hD);

    strobe(16'h12AF);                         // sampled e9
    adv(3);                                   // e12
    slot("old_d2", 8'hFF, 4'hB);
    adv(4);                                   // e16
    slot("old_d3", 8'hFF, 4'h7);
    adv(4);                                   // e20
    slot("12af_d0", 8'h8E, 4'hE);
    adv(4);
    slot("12af_d1", 8'h88, 4'hD);
    adv(4);
    slot("12af_d2", 8'hA4, 4'hB);
    adv(4);                                   // e32
    slot("12af_d3", 8'hF9, 4'h7);

    strobe(16'h0005);                         // e33
    strobe(16'h0030);                         // e34
    adv(2);                                   // e36
    slot("last_d0", 8'hC0, 4'hE);
    adv(4);
    slot("last_d1", 8'hB0, 4'hD);
    adv(4);
    slot("last_d2", 8'hFF, 4'hB);
    adv(4);                                   // e48
    slot("last_d3", 8'hFF, 4'h7);

    adv(3);                                   // e51
    strobe(16'hBEEF);                         // sampled on boundary e52
    slot("bnd_d0", 8'h8E, 4'hE);
    adv(4);
    slot("bnd_d1", 8'h86, 4'hD);
    adv(4);
    slot("bnd_d2", 8'h86, 4'hB);
    adv(4);                                   // e64
    slot("bnd_d3", 8'h83, 4'h7);
    adv(4);                                   // e68
    slot("bnd_hold_d0", 8'h8E, 4'hE);

    bus.in_halt = 1'b1;
    strobe(16'h0000);                         // e69
    adv(3);                                   // e72
    slot("tear_d1", 8'h86, 4'hD);
    adv(8);                                   // e80
    slot("tear_d3", 8'h83, 4'h7);
    adv(4);                                   // e84
    slot("halt_d0", 8'h40, 4'hE);
    adv(4);
    slot("halt_d1", 8'hFF, 4'hD);
    adv(4);
    slot("halt_d2", 8'hFF, 4'hB);
    adv(4);                                   // e96
    slot("halt_d3", 8'hFF, 4'h7);
    adv(4);                                   // e100
    slot("halt_d0b", 8'h40, 4'hE);

    bus.in_halt = 1'b0;
    strobe(16'hFFFF);                         // e101
    adv(15);                                  // e116
    slot("ffff_d0", 8'h8E, 4'hE);
    adv(2);                                   // mid-slot
    rst = 1'b1;
    #1;
    slot("async_rst", 8'hFF, 4'hF);
    adv(2);
    slot("rst_held", 8'hFF, 4'hF);
    release_rst();
    slot("rel", 8'hFF, 4'hF);
    adv(3);
    slot("rel_pre_tick", 8'hFF, 4'hF);
    adv(1);
    slot("rel_d0", 8'hC0, 4'hE);
    adv(4);
    slot("rel_d1", 8'hFF, 4'hD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
